// File: rtl/ras_pkg.sv
// ras_pkg: shared configuration, types and helpers for the return-address-stack
// controller slice.
//   STACK_DEPTH / ENTRY_SIZE / NUM_CKPT : controlled stack geometry and checkpoint count
//   TAIL_W / SIZE_W / ID_W              : derived pointer, occupancy and slot-id widths
//   ras_state_e                         : controller FSM states
//   ras_ckpt_t                          : one checkpoint record
// Optional feature macro: RAS_TOP_REPAIR_EN (adds saved top entry and the REPAIR state).
package ras_pkg;

  localparam int STACK_DEPTH = 8;
  localparam int ENTRY_SIZE  = 64;
  localparam int NUM_CKPT    = 4;

  localparam int TAIL_W = $clog2(STACK_DEPTH);
  localparam int SIZE_W = $clog2(STACK_DEPTH + 1);
  localparam int ID_W   = $clog2(NUM_CKPT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESTORE = 2'd1
`ifdef RAS_TOP_REPAIR_EN
    , REPAIR = 2'd2
`endif
  } ras_state_e;

  typedef struct packed {
    logic [TAIL_W-1:0]     tail;
    logic [SIZE_W-1:0]     size;
`ifdef RAS_TOP_REPAIR_EN
    logic [ENTRY_SIZE-1:0] top;
`endif
  } ras_ckpt_t;

  // Index of the lowest clear bit; 0 when every slot is taken (caller gates with any_free).
  function automatic logic [ID_W-1:0] lowest_free(input logic [NUM_CKPT-1:0] taken);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      idx = taken[i] ? idx : ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: groups the fetch/predictor, checkpoint and stack-side signals of ras_ctrl.
//   master : front-end + stack side (drives call/ret/ckpt/mispredict requests and stack status)
//   slave  : ras_ctrl (drives stack commands, predictions, checkpoint grant and busy)
interface ras_ctrl_if;
  import ras_pkg::*;

  logic                  call_valid;
  logic [ENTRY_SIZE-1:0] call_ret_addr;
  logic                  ret_valid;
  logic                  ckpt_alloc_valid;
  logic                  ckpt_alloc_ready;
  logic [ID_W-1:0]       ckpt_alloc_id;
  logic                  ckpt_free_valid;
  logic [ID_W-1:0]       ckpt_free_id;
  logic                  mispredict_valid;
  logic [ID_W-1:0]       mispredict_id;
  logic [ENTRY_SIZE-1:0] stack_top;
  logic                  stack_empty;
  logic                  push;
  logic                  pop;
  logic                  restoreTail;
  logic [ENTRY_SIZE-1:0] pushee;
  logic [TAIL_W-1:0]     newTail;
  logic                  pred_valid;
  logic [ENTRY_SIZE-1:0] pred_target;
  logic                  busy;

  modport master (
    output call_valid, call_ret_addr, ret_valid, ckpt_alloc_valid,
           ckpt_free_valid, ckpt_free_id, mispredict_valid, mispredict_id,
           stack_top, stack_empty,
    input  ckpt_alloc_ready, ckpt_alloc_id, push, pop, restoreTail,
           pushee, newTail, pred_valid, pred_target, busy
  );

  modport slave (
    input  call_valid, call_ret_addr, ret_valid, ckpt_alloc_valid,
           ckpt_free_valid, ckpt_free_id, mispredict_valid, mispredict_id,
           stack_top, stack_empty,
    output ckpt_alloc_ready, ckpt_alloc_id, push, pop, restoreTail,
           pushee, newTail, pred_valid, pred_target, busy
  );
endinterface

// File: rtl/ras_ckpt_table.sv
// ras_ckpt_table: checkpoint slots for in-flight speculative branches.
//   clk_in, rst_N_in     : clock, async active-low reset (all slots free)
//   alloc_en/alloc_data  : take the lowest free slot (grant_id) and store alloc_data
//   free_en/free_id      : release one slot at the next edge
//   flush_all            : release every slot at the next edge
//   rd_id/rd_data/rd_valid : combinational read of one slot
//   any_free/grant_id    : free-slot indication and lowest-free index
module ras_ckpt_table
  import ras_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_N_in,
  input  logic            alloc_en,
  input  ras_ckpt_t       alloc_data,
  input  logic            free_en,
  input  logic [ID_W-1:0] free_id,
  input  logic            flush_all,
  input  logic [ID_W-1:0] rd_id,
  output ras_ckpt_t       rd_data,
  output logic            rd_valid,
  output logic            any_free,
  output logic [ID_W-1:0] grant_id
);

  ras_ckpt_t           slot_q [NUM_CKPT];
  ras_ckpt_t           slot_d [NUM_CKPT];
  logic [NUM_CKPT-1:0] valid_q;
  logic [NUM_CKPT-1:0] valid_d;

  assign any_free = ~(&valid_q);
  // Grant comes from the registered valid bits, so a slot freed this cycle is not re-grantable yet.
  assign grant_id = lowest_free(valid_q);
  assign rd_data  = slot_q[rd_id];
  assign rd_valid = valid_q[rd_id];

  // Next slot contents and valid bits: flush beats alloc, alloc beats free.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < NUM_CKPT; i++) begin
      slot_d[i] = slot_q[i];
      if (flush_all) begin
        valid_d[i] = 1'b0;
      end else if (alloc_en && (grant_id == ID_W'(i))) begin
        valid_d[i] = 1'b1;
        slot_d[i]  = alloc_data;
      end else if (free_en && (free_id == ID_W'(i))) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // Slot storage and valid-bit registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      valid_q <= {NUM_CKPT{1'b0}};
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: rtl/ras_ctrl_chk.sv
// ras_ctrl_chk: property checks on ras_ctrl.
//   run_s          : controller is in RUN
//   mp_slot_valid  : the slot addressed by mispredict_id is live
//   push/pop/restore_tail : stack commands issued this cycle
module ras_ctrl_chk (
  input logic clk_in,
  input logic rst_N_in,
  input logic run_s,
  input logic mispredict_valid,
  input logic mp_slot_valid,
  input logic push,
  input logic pop,
  input logic restore_tail
);

  a_mp_live_slot: assert property (@(posedge clk_in) disable iff (!rst_N_in)
    (run_s && mispredict_valid) |-> mp_slot_valid);

  a_cmd_exclusive: assert property (@(posedge clk_in) disable iff (!rst_N_in)
    restore_tail |-> !(push || pop));

endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller. Turns call/return predictions into
// push/pop commands, forecasts return targets, checkpoints the stack pointer for
// speculative branches and rewinds the stack on a mispredict.
//   clk_in   : clock, rising edge
//   rst_N_in : asynchronous active-low reset
//   bus      : ras_ctrl_if.slave (call/ret, checkpoint alloc/free, mispredict,
//              stack status in; push/pop/restoreTail/pushee/newTail,
//              pred_valid/pred_target, busy out)
// Optional feature macro: RAS_TOP_REPAIR_EN -- checkpoints also save the top entry
// and a one-cycle REPAIR state rewrites it after RESTORE.
module ras_ctrl
  import ras_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_N_in,
  ras_ctrl_if.slave bus
);

  localparam logic [SIZE_W-1:0] SIZE_FULL = SIZE_W'(STACK_DEPTH);

  ras_state_e        state_q, state_d;
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic [SIZE_W-1:0] size_q, size_d;
  ras_ckpt_t         pend_q, pend_d;

  logic      run_s, mp_hit_s, call_s, ret_s, pop_run_s, repair_s;
  logic      alloc_en_s, free_en_s, flush_s;
  logic      any_free_s, rd_valid_s;
  ras_ckpt_t alloc_data_s, rd_data_s;

  assign run_s    = (state_q == RUN);
`ifdef RAS_TOP_REPAIR_EN
  assign repair_s = (state_q == REPAIR);
`else
  assign repair_s = 1'b0;
`endif
  // A mispredict only acts in RUN and on a live slot; it then squashes the cycle's other requests.
  assign mp_hit_s  = run_s && bus.mispredict_valid && rd_valid_s;
  assign call_s    = run_s && bus.call_valid && !mp_hit_s;
  assign ret_s     = run_s && bus.ret_valid && !mp_hit_s;
  assign pop_run_s = ret_s && (call_s || !bus.stack_empty);

  assign alloc_en_s = bus.ckpt_alloc_valid && bus.ckpt_alloc_ready && !mp_hit_s;
  assign free_en_s  = run_s && bus.ckpt_free_valid && !mp_hit_s;
  // Entering RESTORE means every younger branch is squashed.
  assign flush_s    = (state_q == RESTORE);

  assign bus.push             = call_s || repair_s;
  assign bus.pop              = pop_run_s || repair_s;
  assign bus.restoreTail      = (state_q == RESTORE);
  assign bus.newTail          = (state_q == RESTORE) ? pend_q.tail : {TAIL_W{1'b0}};
  assign bus.busy             = !run_s;
  assign bus.pred_valid       = run_s && bus.ret_valid && !bus.stack_empty;
  assign bus.pred_target      = bus.stack_top;
  assign bus.ckpt_alloc_ready = run_s && any_free_s;

`ifdef RAS_TOP_REPAIR_EN
  assign bus.pushee = call_s ? bus.call_ret_addr :
                      (repair_s ? pend_q.top : {ENTRY_SIZE{1'b0}});
`else
  assign bus.pushee = call_s ? bus.call_ret_addr : {ENTRY_SIZE{1'b0}};
`endif

  // Checkpoint record: pointers after this cycle's call/ret. The saved top is the
  // value pushed this cycle, else the current top (a same-cycle return leaves it stale).
  always_comb begin
    alloc_data_s      = '0;
    alloc_data_s.tail = tail_d;
    alloc_data_s.size = size_d;
`ifdef RAS_TOP_REPAIR_EN
    alloc_data_s.top  = call_s ? bus.call_ret_addr : bus.stack_top;
`endif
  end

  ras_ckpt_table u_ckpt (
    .clk_in     (clk_in),
    .rst_N_in   (rst_N_in),
    .alloc_en   (alloc_en_s),
    .alloc_data (alloc_data_s),
    .free_en    (free_en_s),
    .free_id    (bus.ckpt_free_id),
    .flush_all  (flush_s),
    .rd_id      (bus.mispredict_id),
    .rd_data    (rd_data_s),
    .rd_valid   (rd_valid_s),
    .any_free   (any_free_s),
    .grant_id   (bus.ckpt_alloc_id)
  );

  // FSM next state and shadow tail/size tracking of the stack.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    size_d  = size_q;
    pend_d  = pend_q;
    case (state_q)
      RUN: begin
        if (mp_hit_s) begin
          pend_d  = rd_data_s;
          state_d = RESTORE;
        end else if (call_s && ret_s) begin
          // Top entry replaced in place: pointers do not move.
          tail_d = tail_q;
          size_d = size_q;
        end else if (call_s) begin
          // Full stack overwrites its oldest entry, so size saturates while tail wraps.
          tail_d = tail_q + TAIL_W'(1);
          size_d = (size_q == SIZE_FULL) ? size_q : size_q + SIZE_W'(1);
        end else if (pop_run_s) begin
          tail_d = tail_q - TAIL_W'(1);
          size_d = (size_q == SIZE_W'(0)) ? size_q : size_q - SIZE_W'(1);
        end else begin
          tail_d = tail_q;
          size_d = size_q;
        end
      end
      RESTORE: begin
        tail_d = pend_q.tail;
        size_d = pend_q.size;
`ifdef RAS_TOP_REPAIR_EN
        state_d = REPAIR;
`else
        state_d = RUN;
`endif
      end
`ifdef RAS_TOP_REPAIR_EN
      REPAIR: begin
        state_d = RUN;
      end
`endif
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state, shadow pointers and the latched checkpoint being restored.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= RUN;
      tail_q  <= {TAIL_W{1'b0}};
      size_q  <= {SIZE_W{1'b0}};
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      size_q  <= size_d;
      pend_q  <= pend_d;
    end
  end

  ras_ctrl_chk u_chk (
    .clk_in           (clk_in),
    .rst_N_in         (rst_N_in),
    .run_s            (run_s),
    .mispredict_valid (bus.mispredict_valid),
    .mp_slot_valid    (rd_valid_s),
    .push             (bus.push),
    .pop              (bus.pop),
    .restore_tail     (bus.restoreTail)
  );

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack controller sitting between fetch/branch-prediction and the `stack` storage block. It turns call/return predictions into push/pop commands and forecasts return targets. It holds a small checkpoint table of stack pointers for in-flight speculative branches. On a mispredict it sequences the stack back to the checkpointed pointer over one or two recovery cycles.

## Interface
- `STACK_DEPTH`, 8: entries in the controlled stack; power of two.
- `ENTRY_SIZE`, 64: return-address width.
- `NUM_CKPT`, 4: checkpoint slots; power of two.
- `clk_in`  in  1  clock; all state on rising edge.
- `rst_N_in`  in  1  reset, asynchronous, active-low.
- `call_valid`  in  1  predicted call this cycle.
- `call_ret_addr`  in  ENTRY_SIZE  return address to push.
- `ret_valid`  in  1  predicted return this cycle.
- `ckpt_alloc_valid` / `ckpt_alloc_ready`  in/out  1  checkpoint request handshake.
- `ckpt_alloc_id`  out  $clog2(NUM_CKPT)  slot granted; valid when valid&&ready.
- `ckpt_free_valid`  in  1  branch resolved correct; release slot.
- `ckpt_free_id`  in  $clog2(NUM_CKPT)  slot to release.
- `mispredict_valid`  in  1  branch mispredicted.
- `mispredict_id`  in  $clog2(NUM_CKPT)  slot to restore.
- `stack_top`  in  ENTRY_SIZE  from stack `stack_out`.
- `stack_empty`  in  1  from stack `empty`.
- `push`, `pop`, `restoreTail`  out  1  stack commands.
- `pushee`  out  ENTRY_SIZE  stack write data.
- `newTail`  out  $clog2(STACK_DEPTH)  restore pointer.
- `pred_valid`  out  1  return prediction valid.
- `pred_target`  out  ENTRY_SIZE  predicted return target.
- `busy`  out  1  recovery in progress; fetch must hold call/ret/alloc.

## Operation
- FSM: RUN, RESTORE, REPAIR (REPAIR only with macro). Reset state RUN.
- Shadow `tail` (width $clog2(STACK_DEPTH)) and `size` (width $clog2(STACK_DEPTH+1)) mirror the stack. Both reset to 0.
- RUN, call only: push=1, pushee=call_ret_addr. tail+1 wraps modulo STACK_DEPTH. size saturates at STACK_DEPTH; the oldest entry is overwritten.
- RUN, ret only: if !stack_empty then pop=1, else no pop. size floors at 0, and tail does not move when empty.
- RUN, call and ret together: push=pop=1, pushee=call_ret_addr, and tail/size are unchanged (top replaced).
- `pred_target` = `stack_top`. `pred_valid` = ret_valid && !stack_empty && state==RUN.
- Checkpoint alloc: `ckpt_alloc_ready` = (any free slot) && state==RUN. Grant goes to the lowest-index free slot.
  - The slot records the post-update {tail, size} of the same cycle's call/ret.
- Checkpoint free: the slot becomes free at the next edge. It is not re-grantable in the same cycle it is freed.
- Mispredict, in RUN:
  - Overrides same-cycle call, ret, alloc and free; all are ignored.
  - Latches the slot contents and moves to RESTORE.
  - Mispredict to a free slot is ignored and flagged by an assertion.
- RESTORE, one cycle: restoreTail=1, newTail=saved tail. Shadow tail/size load saved values. All checkpoint slots freed (all younger branches are squashed). Next state RUN, or REPAIR with macro.
- Mispredict asserted while not in RUN is ignored.
- Only one of push/pop-pair or restoreTail is active in a cycle.

## Timing
- Output reset values: push=pop=restoreTail=0, pushee=0, newTail=0, pred_valid=0, busy=0, ckpt_alloc_ready=1, ckpt_alloc_id=0.
- push/pop/pushee/pred_* are combinational from inputs in RUN; zero-latency command to the stack.
- Mispredict seen at edge T: restoreTail high during cycle T+1, and busy high during T+1.
- First new call/ret is accepted at T+2 without the macro, or at T+3 with it.
- ckpt_alloc_id is combinational; the slot is taken at the handshake edge.
- Reset asserted mid-recovery: immediate return to RUN, all slots freed, all outputs to their reset values.

## Configuration
- `RAS_TOP_REPAIR_EN` defined:
  - Each checkpoint also stores the top entry value at allocation.
  - After RESTORE, the FSM enters REPAIR for one cycle: push=pop=1, pushee=saved top, busy=1.
  - This rewrites a top entry clobbered by speculative pushes.
- Undefined: no top storage and no REPAIR state; RESTORE returns directly to RUN.

## Structure
- `ras_pkg`:
  - `ras_state_e` {RUN, RESTORE, REPAIR}.
  - `ras_ckpt_t` {tail, size, top under macro}.
  - Width localparams derived from STACK_DEPTH/NUM_CKPT.
- Sub-module `ras_ckpt_table` holds:
  - slot storage
  - valid bits
  - lowest-free priority encoder
  - free/flush-all ports
- `ras_ctrl` holds the FSM and shadow pointers.

## Test plan
- Reset, then 3 calls (0x100, 0x200, 0x300), then 3 rets -> pred_target 0x300, 0x200, 0x100 with pred_valid=1; a 4th ret gives pred_valid=0 and pop=0.
- 9 calls with STACK_DEPTH=8 -> size stays 8 and tail wraps to 1. 8 rets return the newest 8 addresses, and the 9th gives pred_valid=0.
- Call+ret in the same cycle with top 0x100, addr 0x500 -> push=pop=1, next pred_target 0x500, size unchanged.
- Sequence:
  - Push 0x100, alloc slot 0 (tail=1).
  - Push 0x200, 0x300.
  - mispredict_id=0.
  - Expected: T+1 restoreTail=1, newTail=1, busy=1; afterwards a ret predicts 0x100 and all slots read free.
- With the macro, snapshot top 0x100:
  - Sequence: pop, push 0xBAD, mispredict.
  - Expected: REPAIR cycle writes 0x100, and the next ret predicts 0x100.
- Allocate NUM_CKPT slots -> ckpt_alloc_ready=0. Free slot 2 -> the next cycle's grant is id 2. Assert reset during RESTORE -> all outputs at their reset values immediately.
